// File: rtl/keccak_round_scheduler_if.sv
// keccak_round_scheduler_if
// Bundles the scheduler's handshakes and the control/data lines to the
// external masked Keccak-f[25] core.
// Signals:
//   InValid/InReady/InData       : share-concatenated input handshake
//   RandValid/RandReady/RandData : per-round fresh-randomness handshake
//   OutValid/OutReady/OutData    : result handshake
//   CoreLoad/CoreEnable          : core load-select and state-register update
//   CoreIotaRC/CoreLastround     : round constant bit and last-round flag
//   CoreInData/CoreFreshRand     : gated data towards the core
//   CoreState                    : compressed core state from the core
//   Busy                         : permutation in flight or result pending
// Modports: slave = scheduler side, master = environment/core side.
interface keccak_round_scheduler_if #(
    parameter int SIN = 3,
    parameter int RB  = 75,
    parameter int W   = 1
);
    logic              InValid;
    logic              InReady;
    logic [SIN*25-1:0] InData;
    logic              RandValid;
    logic              RandReady;
    logic [RB-1:0]     RandData;
    logic              OutValid;
    logic              OutReady;
    logic [SIN*25-1:0] OutData;
    logic              CoreLoad;
    logic              CoreEnable;
    logic [W-1:0]      CoreIotaRC;
    logic              CoreLastround;
    logic [SIN*25-1:0] CoreInData;
    logic [RB-1:0]     CoreFreshRand;
    logic [SIN*25-1:0] CoreState;
    logic              Busy;

    modport slave (
        input  InValid, InData, RandValid, RandData, OutReady, CoreState,
        output InReady, RandReady, OutValid, OutData, CoreLoad, CoreEnable,
               CoreIotaRC, CoreLastround, CoreInData, CoreFreshRand, Busy
    );

    modport master (
        output InValid, InData, RandValid, RandData, OutReady, CoreState,
        input  InReady, RandReady, OutValid, OutData, CoreLoad, CoreEnable,
               CoreIotaRC, CoreLastround, CoreInData, CoreFreshRand, Busy
    );
endinterface

// File: rtl/keccak_round_scheduler.sv
// keccak_round_scheduler
// Sequences one masked Keccak-f[25] permutation on an external threshold
// core: loads the input shares, issues ROUNDS round enables paced by the
// fresh-randomness stream, then presents the compressed core state until
// it is taken. Only W=1 (25-bit state) is supported.
// Ports:
//   Clock : sole clock, rising edge
//   Reset : asynchronous active-high reset
//   bus   : keccak_round_scheduler_if.slave (handshakes + core lines)
//
// state | meaning
// IDLE  | InReady high; InValid loads the core and starts a permutation
// ROUND | one round per cycle with RandValid; r = rounds consumed so far
// DONE  | OutValid high with OutData = CoreState until OutReady
module keccak_round_scheduler #(
    parameter int d      = 2,
    parameter int Sin    = d + 1,
    parameter int W      = 1,
    parameter int ROUNDS = 12,
    parameter int RB     = ((Sin * Sin) - Sin) / 2 * 25
) (
    input logic Clock,
    input logic Reset,
    keccak_round_scheduler_if.slave bus
);
    localparam int NB = Sin * 25;
    localparam int RW = $clog2(ROUNDS + 1);
    localparam logic [RW-1:0] LAST_R = RW'(ROUNDS - 1);
    localparam logic [RW-1:0] ONE_R  = RW'(1);
    // LSB of the Keccak-f round constants, bit r = round r; upper bits pad
    // the table to the full 4-bit index range.
    localparam logic [15:0] RC_TABLE = 16'h04F1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ROUND,
        ST_DONE
    } state_t;

    state_t        state_q, state_d;
    logic [RW-1:0] r_q, r_d;
    logic [3:0]    rc_idx;

    logic in_ready, rand_ready, out_valid;
    logic core_load, core_enable, iota_bit, last_round, busy;
    logic in_take, rand_take, out_show;

    assign rc_idx = 4'(r_q);

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q <= ST_IDLE;
            r_q     <= '0;
        end else begin
            state_q <= state_d;
            r_q     <= r_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        r_d         = r_q;
        in_ready    = 1'b0;
        rand_ready  = 1'b0;
        out_valid   = 1'b0;
        core_load   = 1'b0;
        core_enable = 1'b0;
        iota_bit    = 1'b0;
        last_round  = 1'b0;
        busy        = 1'b0;
        in_take     = 1'b0;
        rand_take   = 1'b0;
        out_show    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                in_ready = 1'b1;
                // Reset is asynchronous; keep the accept strobes quiet while
                // it is asserted so nothing is loaded into the core.
                if (bus.InValid && !Reset) begin
                    in_take     = 1'b1;
                    core_load   = 1'b1;
                    core_enable = 1'b1;
                    r_d         = '0;
                    state_d     = ST_ROUND;
                end
            end
            ST_ROUND: begin
                busy       = 1'b1;
                rand_ready = 1'b1;
                iota_bit   = RC_TABLE[rc_idx];
                last_round = (r_q == LAST_R);
                if (bus.RandValid) begin
                    rand_take   = 1'b1;
                    core_enable = 1'b1;
                    r_d         = r_q + ONE_R;
                    if (r_q == LAST_R) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                out_show  = 1'b1;
                if (bus.OutReady) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign bus.InReady       = in_ready;
    assign bus.RandReady     = rand_ready;
    assign bus.OutValid      = out_valid;
    assign bus.CoreLoad      = core_load;
    assign bus.CoreEnable    = core_enable;
    assign bus.CoreIotaRC    = W'(iota_bit);
    assign bus.CoreLastround = last_round;
    assign bus.Busy          = busy;

    // Share buses stay zero unless the value is being handed over right now.
    assign bus.CoreInData    = in_take   ? bus.InData    : {NB{1'b0}};
    assign bus.CoreFreshRand = rand_take ? bus.RandData  : {RB{1'b0}};
    assign bus.OutData       = out_show  ? bus.CoreState : {NB{1'b0}};
endmodule

// File: tb/tb_keccak_round_scheduler.sv
module tb_keccak_round_scheduler;
    localparam int D      = 2;
    localparam int SIN    = D + 1;
    localparam int W      = 1;
    localparam int ROUNDS = 12;
    localparam int RB     = ((SIN * SIN) - SIN) / 2 * 25;
    localparam int NB     = SIN * 25;
    localparam int LOGN   = 1024;

    logic Clock = 1'b0;
    logic Reset = 1'b0;
    always #5 Clock = ~Clock;

    keccak_round_scheduler_if #(.SIN(SIN), .RB(RB), .W(W)) bus ();

    keccak_round_scheduler #(
        .d(D), .Sin(SIN), .W(W), .ROUNDS(ROUNDS), .RB(RB)
    ) dut (
        .Clock(Clock),
        .Reset(Reset),
        .bus(bus.slave)
    );

    // Toy core: load on CoreLoad, otherwise rotate and mix in randomness and iota.
    function automatic logic [NB-1:0] core_step(input logic [NB-1:0] s,
                                                input logic [RB-1:0] rnd,
                                                input logic rc);
        return {s[NB-2:0], s[NB-1]} ^ NB'(rnd) ^ NB'(rc);
    endfunction

    logic [NB-1:0] core_q = '0;
    assign bus.CoreState = core_q;
    always @(posedge Clock) begin
        if (bus.CoreEnable)
            core_q <= bus.CoreLoad ? bus.CoreInData
                                   : core_step(core_q, bus.CoreFreshRand, bus.CoreIotaRC[0]);
    end

    int total = 0;
    int bad   = 0;
    int gcyc  = 0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, gcyc);
        end
    endtask

    task automatic chk_i(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Behavioural model: phase 0 idle, 1 running (m_k rounds consumed), 2 result.
    int            m_phase = 0;
    int            m_k     = 0;
    logic [NB-1:0] m_val   = '0;
    logic          rc_lut [0:11] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1,
                                     1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};

    logic acc_log  [0:LOGN-1];
    logic en_log   [0:LOGN-1];
    logic iota_log [0:LOGN-1];
    logic last_log [0:LOGN-1];
    logic rr_log   [0:LOGN-1];
    logic ov_log   [0:LOGN-1];
    logic inr_log  [0:LOGN-1];
    logic busy_log [0:LOGN-1];

    logic          e_inr, e_rr, e_ov, e_ld, e_en, e_rc, e_last, e_busy;
    logic [NB-1:0] e_cin, e_out;
    logic [RB-1:0] e_fr;

    initial begin
        forever begin
            @(negedge Clock);
            gcyc = gcyc + 1;
            e_inr = 1'b0; e_rr = 1'b0; e_ov = 1'b0; e_ld = 1'b0;
            e_en = 1'b0; e_rc = 1'b0; e_last = 1'b0; e_busy = 1'b0;
            e_cin = '0; e_out = '0; e_fr = '0;
            if (Reset) begin
                e_inr = 1'b1;
            end else begin
                case (m_phase)
                    0: begin
                        e_inr = 1'b1;
                        if (bus.InValid) begin
                            e_ld = 1'b1; e_en = 1'b1; e_cin = bus.InData;
                        end
                    end
                    1: begin
                        e_busy = 1'b1; e_rr = 1'b1;
                        e_rc   = rc_lut[m_k];
                        e_last = (m_k == ROUNDS - 1);
                        if (bus.RandValid) begin
                            e_en = 1'b1; e_fr = bus.RandData;
                        end
                    end
                    default: begin
                        e_busy = 1'b1; e_ov = 1'b1; e_out = m_val;
                    end
                endcase
            end
            chk("InReady",       128'(bus.InReady),       128'(e_inr));
            chk("RandReady",     128'(bus.RandReady),     128'(e_rr));
            chk("OutValid",      128'(bus.OutValid),      128'(e_ov));
            chk("CoreLoad",      128'(bus.CoreLoad),      128'(e_ld));
            chk("CoreEnable",    128'(bus.CoreEnable),    128'(e_en));
            chk("CoreIotaRC",    128'(bus.CoreIotaRC),    128'(e_rc));
            chk("CoreLastround", 128'(bus.CoreLastround), 128'(e_last));
            chk("Busy",          128'(bus.Busy),          128'(e_busy));
            chk("OutData",       128'(bus.OutData),       128'(e_out));
            chk("CoreInData",    128'(bus.CoreInData),    128'(e_cin));
            chk("CoreFreshRand", 128'(bus.CoreFreshRand), 128'(e_fr));
            if (gcyc < LOGN) begin
                acc_log[gcyc]  = bus.CoreLoad;
                en_log[gcyc]   = bus.CoreEnable;
                iota_log[gcyc] = bus.CoreIotaRC[0];
                last_log[gcyc] = bus.CoreLastround;
                rr_log[gcyc]   = bus.RandReady;
                ov_log[gcyc]   = bus.OutValid;
                inr_log[gcyc]  = bus.InReady;
                busy_log[gcyc] = bus.Busy;
            end
            if (Reset) begin
                m_phase = 0;
            end else begin
                case (m_phase)
                    0: if (bus.InValid) begin
                        m_val = bus.InData; m_k = 0; m_phase = 1;
                    end
                    1: if (bus.RandValid) begin
                        m_val = core_step(m_val, bus.RandData, rc_lut[m_k]);
                        m_k = m_k + 1;
                        if (m_k == ROUNDS) m_phase = 2;
                    end
                    default: if (bus.OutReady) m_phase = 0;
                endcase
            end
        end
    end

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    function automatic int first_ov(input int base, input int from, input int to);
        for (int i = from; i <= to; i++)
            if (i < LOGN && ov_log[i] === 1'b1) return i - base;
        return -1;
    endfunction

    function automatic logic [RB-1:0] rnd_rb();
        return RB'({$urandom(), $urandom(), $urandom()});
    endfunction

    function automatic logic [NB-1:0] rnd_nb();
        return NB'({$urandom(), $urandom(), $urandom()});
    endfunction

    int           base;
    int           cnt;
    logic [11:0]  rc_pin;

    initial begin
        rc_pin = 12'b0100_1111_0001;
        bus.InValid = 1'b0; bus.InData = '0;
        bus.RandValid = 1'b0; bus.RandData = '0;
        bus.OutReady = 1'b0;
        #1 Reset = 1'b1;
        repeat (3) @(posedge Clock);
        #1 Reset = 1'b0;

        // Reset then idle
        base = gcyc + 1;
        repeat (3) tick();
        chk("idle_inready", 128'(inr_log[base + 2]), 128'(1));
        chk("idle_outvalid", 128'(ov_log[base + 2]), 128'(0));
        chk("idle_randready", 128'(rr_log[base + 2]), 128'(0));
        chk("idle_enable", 128'(en_log[base + 2]), 128'(0));

        // One op, randomness always available
        bus.InData = rnd_nb(); bus.InValid = 1'b1;
        bus.RandValid = 1'b1; bus.RandData = rnd_rb(); bus.OutReady = 1'b1;
        base = gcyc + 1;
        for (int c = 1; c <= 16; c++) begin
            tick();
            bus.InValid = 1'b0; bus.RandData = rnd_rb();
        end
        chk("a_accept", 128'(acc_log[base]), 128'(1));
        for (int c = 1; c <= 12; c++) begin
            chk("a_iota", 128'(iota_log[base + c]), 128'(rc_pin[c - 1]));
            chk("a_last", 128'(last_log[base + c]), 128'(c == 12));
        end
        cnt = 0;
        for (int i = 0; i <= 15; i++) if (rr_log[base + i] === 1'b1) cnt++;
        chk_i("a_randready_cycles", cnt, 12);
        chk_i("a_outvalid_cycle", first_ov(base, base, base + 15), 13);
        chk("a_idle_after", 128'(inr_log[base + 14]), 128'(1));

        // Stall: RandValid low in cycles 3 and 4
        bus.InData = rnd_nb(); bus.InValid = 1'b1; bus.OutReady = 1'b1;
        base = gcyc + 1;
        for (int c = 1; c <= 18; c++) begin
            tick();
            bus.InValid = 1'b0;
            bus.RandValid = (c != 3 && c != 4);
            bus.RandData = rnd_rb();
        end
        bus.RandValid = 1'b1;
        chk("b_stall_en3", 128'(en_log[base + 3]), 128'(0));
        chk("b_stall_en4", 128'(en_log[base + 4]), 128'(0));
        chk("b_iota_c6", 128'(iota_log[base + 6]), 128'(0));
        chk("b_iota_c7", 128'(iota_log[base + 7]), 128'(1));
        chk("b_last_c14", 128'(last_log[base + 14]), 128'(1));
        chk_i("b_outvalid_cycle", first_ov(base, base, base + 17), 15);

        // Result back-pressure: OutReady low for 5 DONE cycles, InValid ignored
        bus.InData = rnd_nb(); bus.InValid = 1'b1; bus.OutReady = 1'b0;
        base = gcyc + 1;
        for (int c = 1; c <= 22; c++) begin
            tick();
            bus.InValid = (c >= 13 && c <= 18);
            bus.OutReady = (c >= 18);
            bus.RandData = rnd_rb();
        end
        chk("c_ov13", 128'(ov_log[base + 13]), 128'(1));
        chk("c_ov17", 128'(ov_log[base + 17]), 128'(1));
        chk("c_ov18", 128'(ov_log[base + 18]), 128'(1));
        chk("c_ov19", 128'(ov_log[base + 19]), 128'(0));
        chk("c_inready18", 128'(inr_log[base + 18]), 128'(0));
        chk("c_inready19", 128'(inr_log[base + 19]), 128'(1));
        chk("c_noaccept18", 128'(acc_log[base + 18]), 128'(0));
        chk("c_busy19", 128'(busy_log[base + 19]), 128'(0));

        // Reset while r = 6
        bus.InData = rnd_nb(); bus.InValid = 1'b1; bus.OutReady = 1'b1;
        base = gcyc + 1;
        for (int c = 1; c <= 20; c++) begin
            tick();
            bus.InValid = 1'b0;
            Reset = (c == 7);
            bus.RandData = rnd_rb();
        end
        chk("d_iota_c6", 128'(iota_log[base + 6]), 128'(rc_pin[5]));
        chk("d_rr6", 128'(rr_log[base + 6]), 128'(1));
        chk("d_rr7", 128'(rr_log[base + 7]), 128'(0));
        chk("d_en7", 128'(en_log[base + 7]), 128'(0));
        chk("d_busy8", 128'(busy_log[base + 8]), 128'(0));
        chk("d_inready8", 128'(inr_log[base + 8]), 128'(1));
        chk_i("d_no_outvalid", first_ov(base, base, base + 19), -1);

        // Back-to-back: InValid and OutReady held high
        bus.InData = rnd_nb(); bus.InValid = 1'b1; bus.OutReady = 1'b1;
        base = gcyc + 1;
        for (int c = 1; c <= 30; c++) begin
            tick();
            bus.InValid = (c < 15);
            bus.InData = rnd_nb();
            bus.RandData = rnd_rb();
        end
        chk("e_iota_c1", 128'(iota_log[base + 1]), 128'(1));
        chk("e_ov13", 128'(ov_log[base + 13]), 128'(1));
        chk("e_noaccept13", 128'(acc_log[base + 13]), 128'(0));
        chk("e_accept14", 128'(acc_log[base + 14]), 128'(1));
        chk_i("e_second_outvalid", first_ov(base, base + 14, base + 29), 27);

        bus.InValid = 1'b0; bus.RandValid = 1'b0;
        repeat (3) tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/keccak_round_scheduler.md
KECCAK_ROUND_SCHEDULER -- requirements
Module: keccak_round_scheduler

Interface
REQ-001 SHALL have parameter d, default 2, security order.
REQ-002 SHALL have parameter Sin, default d+1, number of input shares.
REQ-003 SHALL have parameter W, default 1, lane size in bits; only W=1 (b=25) is supported.
REQ-004 SHALL have parameter ROUNDS, default 12, rounds per permutation (1..12).
REQ-005 SHALL have parameter RB, default ((Sin*Sin)-Sin)/2*25, fresh-randomness bits per round.
REQ-006 SHALL have port Clock, input, 1, sole clock; all state updates on its rising edge.
REQ-007 SHALL have port Reset, input, 1, asynchronous active-high reset.
REQ-008 SHALL have ports InValid input 1, InReady output 1, InData input Sin*25: share-concatenated input handshake.
REQ-009 SHALL have ports RandValid input 1, RandReady output 1, RandData input RB: per-round fresh-randomness handshake.
REQ-010 SHALL have ports OutValid output 1, OutReady input 1, OutData output Sin*25: result handshake.
REQ-011 SHALL have ports CoreLoad output 1 (core selects InData shares), CoreEnable output 1 (core state register update), CoreIotaRC output W, CoreLastround output 1.
REQ-012 SHALL have ports CoreInData output Sin*25, CoreFreshRand output RB, CoreState input Sin*25 (compressed core state), Busy output 1.

Function
REQ-013 SHALL implement FSM states IDLE, ROUND, DONE plus a round counter r of width ceil(log2(ROUNDS+1)).
REQ-014 IDLE: InReady=1; on InValid: CoreLoad=1, CoreEnable=1, CoreInData=InData, r<=0, next ROUND.
REQ-015 ROUND: RandReady=RandValid-independent 1; CoreIotaRC=RC[r]; when RandValid=1, CoreEnable=1, CoreFreshRand=RandData, r<=r+1.
REQ-016 ROUND stall: RandValid=0 -> CoreEnable=0, r held, CoreIotaRC held, CoreFreshRand=0.
REQ-017 RC table for r=0..11 SHALL be 1,0,0,0,1,1,1,1,0,0,1,0 (LSB of Keccak-f round constants).
REQ-018 CoreLastround SHALL be 1 exactly while in ROUND with r=ROUNDS-1.
REQ-019 Round r=ROUNDS-1 consumed (RandValid=1) -> next DONE.
REQ-020 DONE: OutValid=1, OutData=CoreState; on OutReady -> IDLE next cycle.
REQ-021 InReady SHALL be 0 outside IDLE; InValid outside IDLE is ignored; no input accepted in the DONE-handshake cycle (one-cycle bubble).
REQ-022 OutData, CoreInData, CoreFreshRand SHALL be all-zero whenever not actively used (no share leakage onto idle buses).
REQ-023 CoreLoad and CoreEnable SHALL never both be 1 outside the IDLE accept cycle.
REQ-024 Busy SHALL be 1 in ROUND and DONE.
REQ-025 Latency: accept at cycle 0, no stalls -> rounds in cycles 1..ROUNDS, OutValid at cycle ROUNDS+1 (13 by default); each stall cycle adds one.
REQ-026 RandReady SHALL be 1 only in ROUND; randomness is consumed only when RandValid&RandReady.

Reset
REQ-027 Reset=1 SHALL immediately force IDLE, r=0, and outputs InReady=1, OutValid=0, RandReady=0, CoreLoad=0, CoreEnable=0, CoreLastround=0, CoreIotaRC=0, Busy=0, all data outputs zero.
REQ-028 Reset mid-operation SHALL abandon the permutation without asserting OutValid; first post-reset cycle is IDLE.

Verification
REQ-029 Reset then idle -> InReady=1, OutValid=0, RandReady=0, CoreEnable=0, OutData=0.
REQ-030 One op, RandValid held 1 -> CoreIotaRC 1,0,0,0,1,1,1,1,0,0,1,0 in cycles 1..12, CoreLastround only cycle 12, RandReady high 12 cycles, OutValid cycle 13.
REQ-031 RandValid=0 in cycles 3,4 -> CoreEnable=0 and CoreIotaRC held those cycles, OutValid at cycle 15.
REQ-032 OutReady=0 for 5 cycles in DONE -> OutValid and OutData stable, InReady=0; OutReady=1 -> IDLE and InReady=1 next cycle.
REQ-033 Reset asserted at r=6 -> IDLE next cycle, r=0, no OutValid, all data outputs zero.
REQ-034 InValid held 1, OutReady held 1 -> second accept at cycle 14, second OutValid at cycle 27.
